// File: rtl/pong_pkg.sv
// Shared types for the pong match controller: FSM state encoding, score width
// and winner encodings.
package pong_pkg;

    localparam int SCORE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

endpackage

// File: rtl/match_controller_if.sv
// Signal bundle between the ball/VGA/button side and the match controller.
// The master drives the i_* inputs and observes the o_* results; the slave is the controller.
interface match_controller_if;
    import pong_pkg::*;

    logic               i_animate;
    logic               i_goal_player_1;
    logic               i_goal_player_2;
    logic               i_start;
    logic [SCORE_W-1:0] o_score_player_1;
    logic [SCORE_W-1:0] o_score_player_2;
    logic               o_ball_en;
    logic               o_ball_rst;
    logic               o_serve_dir;
    logic [1:0]         o_winner;
    logic [1:0]         o_state;

    modport master (
        output i_animate, i_goal_player_1, i_goal_player_2, i_start,
        input  o_score_player_1, o_score_player_2, o_ball_en, o_ball_rst,
               o_serve_dir, o_winner, o_state
    );

    modport slave (
        input  i_animate, i_goal_player_1, i_goal_player_2, i_start,
        output o_score_player_1, o_score_player_2, o_ball_en, o_ball_rst,
               o_serve_dir, o_winner, o_state
    );

endinterface

// File: rtl/match_controller_rise_detect.sv
// Rising-edge detector: o_rise is high while i_d is high and its previous sample was low.
// RST_VAL=1 stops a level already high at reset release from looking like a fresh rise.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    logic prev_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) prev_q <= RST_VAL;
        else       prev_q <= i_d;
    end

    assign o_rise = i_d & ~prev_q;

endmodule

// File: rtl/match_controller.sv
// Match sequencing for pong: serve, play, point pause and game over, with both scores.
// Optional build macro MATCH_WIN_BY_TWO_EN: a win needs a lead of two, with a deuce step-back at 15.
module match_controller
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 5,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic               i_clk,
    input  logic               i_rst,
    match_controller_if.slave  bus
);

    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         PAUSE_LOAD = 8'(PAUSE_FRAMES);

    logic goal1_rise, goal2_rise, start_rise;

    rise_detect #(.RST_VAL(1'b1)) u_rise_goal1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(bus.i_goal_player_1), .o_rise(goal1_rise)
    );
    rise_detect #(.RST_VAL(1'b1)) u_rise_goal2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(bus.i_goal_player_2), .o_rise(goal2_rise)
    );
    rise_detect #(.RST_VAL(1'b1)) u_rise_start (
        .i_clk(i_clk), .i_rst(i_rst), .i_d(bus.i_start), .o_rise(start_rise)
    );

    state_e             state_q;
    winner_e            winner_q;
    logic [SCORE_W-1:0] score_p1_q, score_p2_q;
    logic [7:0]         cnt_q;
    logic               ball_en_q, ball_rst_q, serve_dir_q;

    // Outcome of a single-player point, evaluated from the scorer's point of view.
    logic               pt_p1, pt_won, pt_deuce;
    logic [SCORE_W-1:0] scorer_new, other, scorer_adj, other_adj;
    logic [SCORE_W-1:0] nxt_p1, nxt_p2;

    always_comb begin
        pt_p1      = goal1_rise & ~goal2_rise;
        scorer_new = (pt_p1 ? score_p1_q : score_p2_q) + 1'b1;
        other      = pt_p1 ? score_p2_q : score_p1_q;
`ifdef MATCH_WIN_BY_TWO_EN
        pt_won   = (scorer_new >= WIN_VAL) &&
                   ({1'b0, scorer_new} >= ({1'b0, other} + 5'd2));
        // Reaching 15 without winning steps both scores back so nothing can wrap.
        pt_deuce = !pt_won && (scorer_new == {SCORE_W{1'b1}});
`else
        pt_won   = (scorer_new == WIN_VAL);
        pt_deuce = 1'b0;
`endif
        scorer_adj = pt_deuce ? scorer_new - SCORE_W'(1) : scorer_new;
        other_adj  = pt_deuce ? other - SCORE_W'(1) : other;
        nxt_p1     = pt_p1 ? scorer_adj : other_adj;
        nxt_p2     = pt_p1 ? other_adj : scorer_adj;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            winner_q    <= WIN_NONE;
            score_p1_q  <= '0;
            score_p2_q  <= '0;
            cnt_q       <= '0;
            ball_en_q   <= 1'b0;
            ball_rst_q  <= 1'b0;
            serve_dir_q <= 1'b0;
        end else begin
            ball_rst_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_rise) begin
                        ball_rst_q  <= 1'b1;
                        serve_dir_q <= 1'b0;
                        ball_en_q   <= 1'b1;
                        state_q     <= PLAY;
                    end
                end
                PLAY: begin
                    if (goal1_rise || goal2_rise) begin
                        ball_en_q <= 1'b0;
                        if (goal1_rise && goal2_rise) begin
                            state_q <= PAUSE;
                            cnt_q   <= PAUSE_LOAD;
                        end else begin
                            score_p1_q  <= nxt_p1;
                            score_p2_q  <= nxt_p2;
                            // Next serve goes toward the player who conceded.
                            serve_dir_q <= pt_p1;
                            if (pt_won) begin
                                state_q  <= OVER;
                                winner_q <= pt_p1 ? WIN_P1 : WIN_P2;
                            end else begin
                                state_q <= PAUSE;
                                cnt_q   <= PAUSE_LOAD;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (bus.i_animate) begin
                        if (cnt_q == 8'd1) begin
                            cnt_q      <= '0;
                            ball_rst_q <= 1'b1;
                            ball_en_q  <= 1'b1;
                            state_q    <= PLAY;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                OVER: begin
                    if (start_rise) begin
                        score_p1_q  <= '0;
                        score_p2_q  <= '0;
                        winner_q    <= WIN_NONE;
                        serve_dir_q <= 1'b0;
                        cnt_q       <= PAUSE_LOAD;
                        state_q     <= PAUSE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_score_player_1 = score_p1_q;
    assign bus.o_score_player_2 = score_p2_q;
    assign bus.o_ball_en        = ball_en_q;
    assign bus.o_ball_rst       = ball_rst_q;
    assign bus.o_serve_dir      = serve_dir_q;
    assign bus.o_winner         = winner_q;
    assign bus.o_state          = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: serve, goal/pause, simultaneous goals, win/restart,
// reset mid-pause on a long-pause instance, and the MATCH_WIN_BY_TWO_EN deuce path when built with it.
module tb_match_controller;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    match_controller_if m0 ();
    match_controller_if m1 ();

    match_controller #(.WIN_SCORE(5), .PAUSE_FRAMES(3)) dut (
        .i_clk(clk), .i_rst(rst), .bus(m0.slave)
    );

    match_controller #(.WIN_SCORE(5), .PAUSE_FRAMES(45)) dut_long (
        .i_clk(clk), .i_rst(rst2), .bus(m1.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_animate();
        m0.i_animate = 1'b0;
        tick();
        m0.i_animate = 1'b1;
        tick();
        m0.i_animate = 1'b0;
    endtask

    // From PAUSE: finish the pause, then give one point to player 1 (p=1) or player 2 (p=0).
    task automatic goal_point(input logic p);
        repeat (3) pulse_animate();
        if (p) m0.i_goal_player_1 = 1'b1;
        else   m0.i_goal_player_2 = 1'b1;
        tick();
        m0.i_goal_player_1 = 1'b0;
        m0.i_goal_player_2 = 1'b0;
        tick();
    endtask

    initial begin
        m0.i_animate = 0; m0.i_goal_player_1 = 0; m0.i_goal_player_2 = 0; m0.i_start = 1;
        m1.i_animate = 0; m1.i_goal_player_1 = 0; m1.i_goal_player_2 = 0; m1.i_start = 0;
        rst  = 1'b1;
        rst2 = 1'b1;
        repeat (2) tick();
        check("rst_state",  m0.o_state, 0);
        check("rst_score1", m0.o_score_player_1, 0);
        check("rst_score2", m0.o_score_player_2, 0);
        check("rst_winner", m0.o_winner, 0);
        check("rst_ball_en", m0.o_ball_en, 0);
        check("rst_ball_rst", m0.o_ball_rst, 0);
        check("rst_dir", m0.o_serve_dir, 0);

        // Start held high through reset must not count as a rise.
        rst = 1'b0;
        repeat (3) tick();
        check("no_spurious_start", m0.o_state, 0);
        m0.i_start = 1'b0;
        tick();
        m0.i_start = 1'b1;
        tick();
        check("start_state", m0.o_state, 1);
        check("start_ball_rst", m0.o_ball_rst, 1);
        check("start_ball_en", m0.o_ball_en, 1);
        check("start_score1", m0.o_score_player_1, 0);
        check("start_score2", m0.o_score_player_2, 0);
        m0.i_start = 1'b0;
        tick();
        check("ball_rst_one_cycle", m0.o_ball_rst, 0);

        // Goal level held for 100 cycles scores once.
        m0.i_goal_player_1 = 1'b1;
        tick();
        check("goal1_score", m0.o_score_player_1, 1);
        check("goal1_dir", m0.o_serve_dir, 1);
        check("goal1_state", m0.o_state, 2);
        check("goal1_ball_en", m0.o_ball_en, 0);
        repeat (99) tick();
        check("goal1_held_score", m0.o_score_player_1, 1);
        m0.i_goal_player_1 = 1'b0;
        tick();
        pulse_animate();
        pulse_animate();
        check("pause_after_2", m0.o_state, 2);
        check("pause_no_rst", m0.o_ball_rst, 0);
        pulse_animate();
        check("pause_end_state", m0.o_state, 1);
        check("pause_end_ball_rst", m0.o_ball_rst, 1);
        check("pause_end_ball_en", m0.o_ball_en, 1);
        tick();
        check("pause_end_rst_drop", m0.o_ball_rst, 0);

        m0.i_start = 1'b1;
        tick();
        check("start_in_play_ignored", m0.o_state, 1);
        m0.i_start = 1'b0;

        // Simultaneous goals: no score change, pause, direction kept.
        m0.i_goal_player_1 = 1'b1;
        m0.i_goal_player_2 = 1'b1;
        tick();
        check("both_state", m0.o_state, 2);
        check("both_score1", m0.o_score_player_1, 1);
        check("both_score2", m0.o_score_player_2, 0);
        check("both_dir", m0.o_serve_dir, 1);
        m0.i_goal_player_1 = 1'b0;
        m0.i_goal_player_2 = 1'b0;
        tick();
        repeat (3) pulse_animate();
        check("both_back_play", m0.o_state, 1);

        // Player 2 runs to five.
        for (int i = 1; i <= 5; i++) exp_q.push_back(32'(i));
        for (int i = 0; i < 5; i++) begin
            m0.i_goal_player_2 = 1'b1;
            tick();
            check("p2_score", m0.o_score_player_2, exp_q.pop_front());
            check("p2_dir", m0.o_serve_dir, 0);
            m0.i_goal_player_2 = 1'b0;
            tick();
            if (i < 4) begin
                check("p2_pause", m0.o_state, 2);
                repeat (3) pulse_animate();
            end else begin
                check("win_state", m0.o_state, 3);
                check("win_winner", m0.o_winner, 2);
                check("win_ball_en", m0.o_ball_en, 0);
            end
        end
        m0.i_goal_player_1 = 1'b1;
        tick();
        m0.i_goal_player_1 = 1'b0;
        tick();
        check("over_goal_ignored", m0.o_score_player_1, 1);
        check("over_state_held", m0.o_state, 3);
        m0.i_start = 1'b1;
        tick();
        check("restart_state", m0.o_state, 2);
        check("restart_score1", m0.o_score_player_1, 0);
        check("restart_score2", m0.o_score_player_2, 0);
        check("restart_winner", m0.o_winner, 0);
        check("restart_dir", m0.o_serve_dir, 0);
        m0.i_start = 1'b0;
        tick();

`ifdef MATCH_WIN_BY_TWO_EN
        for (int i = 0; i < 4; i++) begin
            goal_point(1'b1);
            goal_point(1'b0);
        end
        goal_point(1'b1);
        check("wb2_5_4_score1", m0.o_score_player_1, 5);
        check("wb2_5_4_winner", m0.o_winner, 0);
        check("wb2_5_4_state", m0.o_state, 2);
        goal_point(1'b1);
        check("wb2_6_4_winner", m0.o_winner, 1);
        check("wb2_6_4_state", m0.o_state, 3);
        m0.i_start = 1'b1;
        tick();
        m0.i_start = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) begin
            goal_point(1'b1);
            goal_point(1'b0);
        end
        check("wb2_14_14_p1", m0.o_score_player_1, 14);
        check("wb2_14_14_p2", m0.o_score_player_2, 14);
        goal_point(1'b1);
        check("wb2_deuce_p1", m0.o_score_player_1, 14);
        check("wb2_deuce_p2", m0.o_score_player_2, 13);
        check("wb2_deuce_winner", m0.o_winner, 0);
        check("wb2_deuce_state", m0.o_state, 2);
`endif

        // Long-pause instance: reset with the counter at 40.
        rst2 = 1'b0;
        tick();
        m1.i_start = 1'b1;
        tick();
        m1.i_start = 1'b0;
        m1.i_goal_player_1 = 1'b1;
        tick();
        m1.i_goal_player_1 = 1'b0;
        check("long_pause_state", m1.o_state, 2);
        repeat (5) begin
            m1.i_animate = 1'b1;
            tick();
            m1.i_animate = 1'b0;
            tick();
        end
        check("long_pause_mid", m1.o_state, 2);
        rst2 = 1'b1;
        tick();
        check("midrst_state", m1.o_state, 0);
        check("midrst_score1", m1.o_score_player_1, 0);
        check("midrst_dir", m1.o_serve_dir, 0);
        check("midrst_ball_en", m1.o_ball_en, 0);
        check("midrst_ball_rst", m1.o_ball_rst, 0);
        check("midrst_winner", m1.o_winner, 0);
        rst2 = 1'b0;
        repeat (45) begin
            m1.i_animate = 1'b1;
            tick();
            m1.i_animate = 1'b0;
            tick();
        end
        check("midrst_stays_idle", m1.o_state, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
